// File: rtl/clk_mon.sv
// Clock-health monitor: measures div_clk half-periods in clk_in cycles,
// reports full period, tracks lock, and flags illegal halves and stalls.
module clk_mon #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MIN_HALF = 5,
    parameter int unsigned MAX_HALF = 7,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             div_clk,
    input  logic             clear,
    output logic [CNT_W:0]   period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic             stall
);

    localparam int unsigned      GOOD_W      = $clog2(LOCK_CNT + 1);
    localparam int unsigned      PER_W       = CNT_W + 1;
    localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_HALF);
    localparam logic [CNT_W-1:0] TO_C        = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1_C     = CNT_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] LAST_GOOD_C = GOOD_W'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  h_q, h_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic              hi_v_q, hi_v_d;
    logic [CNT_W:0]    period_q, period_d;
    logic              pv_q, pv_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic              stall_q, stall_d;

    logic edge_c, rise_c, legal_c, stall_ev_c;

    assign edge_c     = s2_q ^ s3_q;
    assign rise_c     = edge_c & s2_q;
    assign legal_c    = (h_q >= MIN_C) && (h_q <= MAX_C);
    assign stall_ev_c = !edge_c && (h_q == TO_M1_C);

    // Half counter restarts at 1 on an edge and saturates at TIMEOUT.
    always_comb begin
        h_d = h_q;
        if (edge_c) begin
            h_d = CNT_W'(1);
        end else if (h_q != TO_C) begin
            h_d = h_q + CNT_W'(1);
        end
    end

    // Lock FSM, half pairing and fault/stall flags.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        hi_d     = hi_q;
        hi_v_d   = hi_v_q;
        period_d = period_q;
        pv_d     = 1'b0;
        fault_d  = fault_q & ~clear;
        stall_d  = stall_q;

        if (stall_ev_c) begin
            state_d = IDLE;
            good_d  = '0;
            hi_v_d  = 1'b0;
            stall_d = 1'b1;
            fault_d = 1'b1;
        end else if (edge_c) begin
            stall_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // First edge closes a partial half, so it is not measured.
                    state_d = ACQUIRE;
                    good_d  = '0;
                    hi_v_d  = 1'b0;
                end
                default: begin
                    if (rise_c) begin
                        if (hi_v_q) begin
                            period_d = PER_W'(hi_q) + PER_W'(h_q);
                            pv_d     = 1'b1;
                        end
                        hi_v_d = 1'b0;
                    end else begin
                        hi_d   = h_q;
                        hi_v_d = 1'b1;
                    end

                    if (legal_c) begin
                        if (state_q == ACQUIRE) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_q == LAST_GOOD_C) begin
                                state_d = LOCKED;
                            end
                        end
                    end else begin
                        fault_d = 1'b1;
                        good_d  = '0;
                        state_d = ACQUIRE;
                    end
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            h_q      <= CNT_W'(1);
            good_q   <= '0;
            hi_q     <= '0;
            hi_v_q   <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= div_clk;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            h_q      <= h_d;
            good_q   <= good_d;
            hi_q     <= hi_d;
            hi_v_q   <= hi_v_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            stall_q  <= stall_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: edge-timestamp model checked every cycle, plus directed literal checks.
module tb_clk_mon;

    localparam int CNT_W    = 8;
    localparam int MIN_HALF = 5;
    localparam int MAX_HALF = 7;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 32;

    logic             clk_in  = 1'b0;
    logic             reset   = 1'b1;
    logic             div_clk = 1'b0;
    logic             clear   = 1'b0;
    logic [CNT_W:0]   period;
    logic             period_valid;
    logic             locked;
    logic             fault;
    logic             stall;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk_in = ~clk_in;

    clk_mon #(
        .CNT_W   (CNT_W),
        .MIN_HALF(MIN_HALF),
        .MAX_HALF(MAX_HALF),
        .LOCK_CNT(LOCK_CNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .div_clk     (div_clk),
        .clear       (clear),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault),
        .stall       (stall)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // Model: div_clk level sampled at every post-reset clock; an edge is
    // seen two clocks after the sampled level changes, and a half length is
    // the distance between consecutive edge cycles.
    bit hist[$];
    int m_mode   = 0;    // 0 idle, 1 acquire, 2 locked
    int m_good   = 0;
    int m_last   = 0;
    int m_hl     = 0;
    bit m_hv     = 1'b0;
    int m_period = 0;
    bit m_pv     = 1'b0;
    bit m_fault  = 1'b0;
    bit m_stall  = 1'b0;

    function automatic bit lvl(input int i);
        if (i < 1) return 1'b0;
        return hist[i-1];
    endfunction

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_mode = 0; m_good = 0; m_last = 0; m_hl = 0; m_hv = 1'b0;
            m_period = 0; m_pv = 1'b0; m_fault = 1'b0; m_stall = 1'b0;
        end else begin
            int  n;
            int  len;
            bit  ev;
            bit  rise;
            hist.push_back(div_clk);
            n    = hist.size();
            ev   = lvl(n - 2) != lvl(n - 3);
            rise = lvl(n - 2);
            len  = n - m_last;
            m_pv = 1'b0;
            if (clear) m_fault = 1'b0;
            if (ev) begin
                m_stall = 1'b0;
                if (m_mode == 0) begin
                    m_mode = 1; m_good = 0; m_hv = 1'b0;
                end else begin
                    if (rise) begin
                        if (m_hv) begin
                            m_period = m_hl + len;
                            m_pv     = 1'b1;
                        end
                        m_hv = 1'b0;
                    end else begin
                        m_hl = len;
                        m_hv = 1'b1;
                    end
                    if (len >= MIN_HALF && len <= MAX_HALF) begin
                        m_good++;
                        if (m_mode == 1 && m_good >= LOCK_CNT) m_mode = 2;
                    end else begin
                        m_fault = 1'b1; m_good = 0; m_mode = 1;
                    end
                end
                m_last = n;
            end else if (len == TIMEOUT - 1) begin
                m_stall = 1'b1; m_fault = 1'b1; m_mode = 0; m_good = 0; m_hv = 1'b0;
            end
        end
    end

    always @(negedge clk_in) begin
        cyc++;
        if (chk_en) begin
            chk("period",       int'(period),       m_period);
            chk("period_valid", int'(period_valid), int'(m_pv));
            chk("locked",       int'(locked),       int'(m_mode == 2));
            chk("fault",        int'(fault),        int'(m_fault));
            chk("stall",        int'(stall),        int'(m_stall));
        end
    end

    task automatic half(input int len);
        div_clk = ~div_clk;
        repeat (len) @(negedge clk_in);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1 chk_en = 1'b1;
        @(negedge clk_in);
        chk("rst_period", int'(period), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault",  int'(fault),  0);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);

        // Nominal 6/6: first edge ignored, lock on 4th captured half.
        repeat (4) half(6);
        chk("nom_lock_early", int'(locked), 0);
        half(6);
        chk("nom_locked", int'(locked), 1);
        chk("nom_fault",  int'(fault),  0);
        chk("nom_period", int'(period), 12);

        // One 4-cycle high half while locked.
        half(6);
        half(4);
        half(6);
        chk("inj_fault",  int'(fault),  1);
        chk("inj_locked", int'(locked), 0);
        half(6);
        chk("inj_period", int'(period), 10);
        repeat (3) half(6);
        chk("inj_relock", int'(locked), 1);
        chk("inj_sticky", int'(fault),  1);

        // Clear alone, then clear colliding with an illegal half.
        pulse_clear();
        chk("clr_fault", int'(fault), 0);
        half(3);
        div_clk = ~div_clk;
        repeat (2) @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        chk("clr_vs_set", int'(fault), 1);
        repeat (3) @(negedge clk_in);

        // Relock, clear, then hold div_clk for a stall.
        repeat (4) half(6);
        chk("pre_stall_lock", int'(locked), 1);
        pulse_clear();
        chk("pre_stall_clr", int'(fault), 0);
        div_clk = ~div_clk;
        repeat (33) @(negedge clk_in);
        chk("stall_early",  int'(stall),  0);
        chk("lock_early",   int'(locked), 1);
        @(negedge clk_in);
        chk("stall_set",    int'(stall),  1);
        chk("stall_fault",  int'(fault),  1);
        chk("stall_unlock", int'(locked), 0);
        repeat (4) @(negedge clk_in);

        // Resume toggling.
        half(6);
        chk("resume_stall", int'(stall), 0);
        repeat (5) half(6);
        chk("resume_lock", int'(locked), 1);

        // Asynchronous reset between clock edges.
        @(posedge clk_in);
        #2 reset = 1'b1;
        #1;
        chk("areset_period", int'(period),       0);
        chk("areset_pv",     int'(period_valid), 0);
        chk("areset_locked", int'(locked),       0);
        chk("areset_fault",  int'(fault),        0);
        chk("areset_stall",  int'(stall),        0);
        div_clk = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (6) @(negedge clk_in);
        repeat (3) half(6);
        chk("rlk_early", int'(locked), 0);
        half(6);
        chk("rlk_locked", int'(locked), 1);

        // 7-cycle halves are legal, an 8 is not.
        repeat (4) half(7);
        chk("h7_period", int'(period), 14);
        chk("h7_locked", int'(locked), 1);
        chk("h7_fault",  int'(fault),  0);
        half(8);
        half(6);
        chk("h8_fault",  int'(fault),  1);
        chk("h8_locked", int'(locked), 0);
        repeat (2) half(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
